// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

    // Bit offset of a byte lane inside a word for the selected byte order.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane, input logic big_endian);
        logic [1:0] pos;
        if (big_endian) begin
            pos = 2'd3 - lane;
        end else begin
            pos = lane;
        end
        return {pos, 3'b000};
    endfunction

endpackage

// File: rtl/instr_byte_packer.sv
// Packs a byte stream into 32-bit words; the assembled word (including the
// byte being sampled) is presented in the same cycle so it can be written at once.
module instr_byte_packer
    import instr_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic [7:0]         byte_i,
    input  logic               valid_i,
    input  logic               last_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_valid_o,
    output logic               partial_o
);

    logic [1:0]         lane_q, lane_d;
    logic [INSTR_W-1:0] acc_q, acc_d;
    logic [INSTR_W-1:0] merged_s;
    logic               lane_full_s;

    assign lane_full_s = (lane_q == 2'd3);

    // Merge the incoming byte and advance or restart the lane counter.
    always_comb begin
        merged_s = acc_q | ({24'd0, byte_i} << lane_shift(lane_q, BIG_ENDIAN));
        lane_d   = lane_q;
        acc_d    = acc_q;
        if (clear_i) begin
            lane_d = 2'd0;
            acc_d  = {INSTR_W{1'b0}};
        end else if (valid_i) begin
            if (lane_full_s || last_i) begin
                lane_d = 2'd0;
                acc_d  = {INSTR_W{1'b0}};
            end else begin
                lane_d = lane_q + 2'd1;
                acc_d  = merged_s;
            end
        end else begin
            lane_d = lane_q;
            acc_d  = acc_q;
        end
    end

    assign word_o       = merged_s;
    assign word_valid_o = valid_i && !clear_i && lane_full_s;
    assign partial_o    = valid_i && !clear_i && last_i && !lane_full_s;

    // Lane counter and partial-word accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            acc_q  <= {INSTR_W{1'b0}};
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory filled at run time from a byte stream, with a registered
// one-cycle fetch port that flags misaligned and out-of-range addresses.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [7:0]                 ld_byte,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       ld_overflow,
    output logic [$clog2(DEPTH+1)-1:0] ld_words,
    output logic                       busy,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       fetch_valid,
    output logic [INSTR_W-1:0]         fetch_instr,
    output logic                       fetch_fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_q, clr_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic               ovf_q, ovf_d;
    logic               fvalid_q;
    logic               ffault_q;
    logic [INSTR_W-1:0] finstr_q;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_waddr_s;
    logic [INSTR_W-1:0] mem_wdata_s;
    logic               pk_valid_s, pk_clear_s;
    logic [INSTR_W-1:0] pk_word_s;
    logic               pk_word_valid_s, pk_partial_s;
    logic               ptr_full_s;
    logic [ADDR_W-3:0]  word_addr_s;
    logic               fault_s;

    instr_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pk_clear_s),
        .byte_i       (ld_byte),
        .valid_i      (pk_valid_s),
        .last_i       (ld_last),
        .word_o       (pk_word_s),
        .word_valid_o (pk_word_valid_s),
        .partial_o    (pk_partial_s)
    );

    assign ptr_full_s = (ptr_q == CNT_W'(DEPTH));

    // Session control: ld_start overrides everything; CLEAR and LOAD share the write port.
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = {IDX_W{1'b0}};
        mem_wdata_s = {INSTR_W{1'b0}};
        pk_valid_s  = 1'b0;
        pk_clear_s  = 1'b0;
        if (ld_start) begin
            state_d    = ST_CLEAR;
            clr_d      = {IDX_W{1'b0}};
            ptr_d      = {CNT_W{1'b0}};
            ovf_d      = 1'b0;
            pk_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = clr_q;
                    clr_d       = clr_q + IDX_W'(1);
                    if (clr_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        // Bytes past the last word are dropped, but ld_last still ends the session.
                        if (ptr_full_s) begin
                            ovf_d = 1'b1;
                        end else begin
                            pk_valid_s = 1'b1;
                            if (pk_word_valid_s || pk_partial_s) begin
                                mem_we_s    = 1'b1;
                                mem_waddr_s = ptr_q[IDX_W-1:0];
                                mem_wdata_s = pk_word_s;
                                ptr_d       = ptr_q + CNT_W'(1);
                            end else begin
                                ptr_d = ptr_q;
                            end
                        end
                        if (ld_last) begin
                            state_d = ST_READY;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and load-session counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            clr_q   <= {IDX_W{1'b0}};
            ptr_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign word_addr_s = fetch_addr[ADDR_W-1:2];
    assign fault_s     = (fetch_addr[1:0] != 2'b00) || (word_addr_s >= (ADDR_W-2)'(DEPTH));

    // Fetch response register; data and fault hold while no response is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvalid_q <= 1'b0;
            ffault_q <= 1'b0;
            finstr_q <= {INSTR_W{1'b0}};
        end else if (fetch_req && (state_q == ST_READY)) begin
            fvalid_q <= 1'b1;
            ffault_q <= fault_s;
            finstr_q <= fault_s ? {INSTR_W{1'b0}} : mem_q[word_addr_s[IDX_W-1:0]];
        end else begin
            fvalid_q <= 1'b0;
        end
    end

    assign ld_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    assign ld_overflow = ovf_q;
    assign ld_words    = ptr_q;
    assign fetch_valid = fvalid_q;
    assign fetch_fault = ffault_q;
    assign fetch_instr = finstr_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomized bench: two instances (big- and little-endian) share stimulus and are
// checked against a byte-list model of the loaded program.
module tb_instr_mem_loadable;

    localparam int DEPTH = 128;
    localparam int CAP   = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, fetch_req = 1'b0;
    logic [7:0]  ld_byte = 8'd0;
    logic [31:0] fetch_addr = 32'd0;

    logic        ld_ready, ld_overflow, busy, fetch_valid, fetch_fault;
    logic [7:0]  ld_words;
    logic [31:0] fetch_instr;
    logic        le_ld_ready, le_ld_overflow, le_busy, le_fetch_valid, le_fetch_fault;
    logic [7:0]  le_ld_words;
    logic [31:0] le_fetch_instr;

    instr_mem_loadable #(.DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_overflow(ld_overflow), .ld_words(ld_words), .busy(busy),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
    );

    instr_mem_loadable #(.DEPTH(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(le_ld_ready),
        .ld_overflow(le_ld_overflow), .ld_words(le_ld_words), .busy(le_busy),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(le_fetch_valid),
        .fetch_instr(le_fetch_instr), .fetch_fault(le_fetch_fault)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  prog[$];
    logic [7:0]  pend[$];
    logic [31:0] last_be = 32'd0;
    logic [31:0] last_le = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word idx as the spec's packing rules build it from the accepted byte list.
    function automatic logic [31:0] model_word(input int idx, input bit be);
        logic [31:0] w;
        int          k;
        w = 32'd0;
        for (int l = 0; l < 4; l++) begin
            k = idx * 4 + l;
            if (k < prog.size() && k < CAP) begin
                if (be) w[8*(3-l) +: 8] = prog[k];
                else    w[8*l +: 8]     = prog[k];
            end
        end
        return w;
    endfunction

    function automatic int model_words(input bit ended);
        int m;
        m = (prog.size() < CAP) ? prog.size() : CAP;
        return ended ? (m + 3) / 4 : m / 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_clear(input bit with_byte);
        int cnt;
        ld_start = 1'b1; ld_valid = with_byte; ld_byte = 8'hEE; ld_last = 1'b0;
        step();
        ld_start = 1'b0; ld_valid = 1'b0;
        prog.delete();
        check_val("start_busy", busy, 32'd1);
        check_val("start_words", ld_words, 32'd0);
        check_val("start_ovf", ld_overflow, 32'd0);
        check_val("start_ready", ld_ready, 32'd0);
        cnt = 1;
        while (ld_ready == 1'b0 && cnt < 300) begin
            step();
            if (ld_ready == 1'b0) cnt++;
        end
        check_val("clear_cycles", cnt, DEPTH);
        check_val("load_busy", busy, 32'd1);
    endtask

    task automatic stream_bytes(input bit with_last);
        int  n;
        bit  fr;
        n = pend.size();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                step();
            end
            fr = ($urandom_range(0, 1) == 1);
            ld_valid = 1'b1; ld_byte = pend[i]; ld_last = with_last && (i == n - 1);
            fetch_req = fr; fetch_addr = 32'd0;
            step();
            prog.push_back(pend[i]);
            if (fr) check_val("fetch_in_load", fetch_valid, 32'd0);
            check_val("words_progress", ld_words, model_words(with_last && (i == n - 1)));
            check_val("ovf_progress", ld_overflow, (prog.size() > CAP) ? 32'd1 : 32'd0);
        end
        ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;
        pend.delete();
    endtask

    task automatic finish_checks();
        check_val("end_words", ld_words, model_words(1'b1));
        check_val("end_ovf", ld_overflow, (prog.size() > CAP) ? 32'd1 : 32'd0);
        check_val("end_busy", busy, 32'd0);
        check_val("end_ready", ld_ready, 32'd0);
    endtask

    task automatic fetch_one(input logic [31:0] a);
        bit flt;
        fetch_req = 1'b1; fetch_addr = a;
        step();
        flt = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        last_be = flt ? 32'd0 : model_word(int'(a >> 2), 1'b1);
        last_le = flt ? 32'd0 : model_word(int'(a >> 2), 1'b0);
        check_val("fetch_valid", fetch_valid, 32'd1);
        check_val("fetch_fault", fetch_fault, flt ? 32'd1 : 32'd0);
        check_val("fetch_instr_be", fetch_instr, last_be);
        check_val("fetch_instr_le", le_fetch_instr, last_le);
    endtask

    task automatic fetch_idle();
        fetch_req = 1'b0;
        step();
        check_val("idle_valid", fetch_valid, 32'd0);
        check_val("hold_instr_be", fetch_instr, last_be);
        check_val("hold_instr_le", le_fetch_instr, last_le);
    endtask

    task automatic fetch_random(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                default: a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0200;
            endcase
            fetch_one(a);
        end
        fetch_idle();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ready"}, ld_ready, 32'd0);
        check_val({tag, "_ovf"}, ld_overflow, 32'd0);
        check_val({tag, "_words"}, ld_words, 32'd0);
        check_val({tag, "_busy"}, busy, 32'd0);
        check_val({tag, "_fvalid"}, fetch_valid, 32'd0);
        check_val({tag, "_finstr"}, fetch_instr, 32'd0);
        check_val({tag, "_ffault"}, fetch_fault, 32'd0);
        check_val({tag, "_le_finstr"}, le_fetch_instr, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        step(); step();
        rst_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'd0;
        step();
        check_val("fetch_in_idle", fetch_valid, 32'd0);
        fetch_req = 1'b0;

        // Directed program from the bring-up example.
        start_clear(1'b0);
        pend = {8'h00, 8'h50, 8'h05, 8'h13};
        stream_bytes(1'b1);
        finish_checks();
        check_val("t1_words", ld_words, 32'd1);
        fetch_one(32'h0);
        check_val("t1_instr", fetch_instr, 32'h0050_0513);
        fetch_one(32'h4);
        check_val("t1_word1_zero", fetch_instr, 32'd0);
        fetch_idle();

        // Partial final word in both byte orders.
        start_clear(1'b0);
        pend = {8'hAA, 8'hBB};
        stream_bytes(1'b1);
        finish_checks();
        fetch_one(32'h0);
        check_val("partial_be", fetch_instr, 32'hAABB_0000);
        check_val("partial_le", le_fetch_instr, 32'h0000_BBAA);
        fetch_idle();

        // Fault cases, back-to-back fetches, random fetch mix.
        start_clear(1'b0);
        for (int i = 0; i < 40; i++) pend.push_back(8'($urandom));
        stream_bytes(1'b1);
        finish_checks();
        fetch_one(32'h2);
        check_val("fault_misalign", fetch_fault, 32'd1);
        fetch_one(32'h200);
        check_val("fault_range", fetch_fault, 32'd1);
        check_val("fault_instr", fetch_instr, 32'd0);
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        fetch_idle();
        fetch_random(20);

        // Overflow: one byte beyond capacity.
        start_clear(1'b0);
        for (int i = 0; i < CAP + 1; i++) pend.push_back(8'($urandom));
        stream_bytes(1'b1);
        finish_checks();
        check_val("ovf_words", ld_words, 32'd128);
        check_val("ovf_flag", ld_overflow, 32'd1);
        fetch_one(32'h1FC);
        fetch_random(20);

        // Restart in the middle of LOAD with a colliding byte.
        start_clear(1'b0);
        for (int i = 0; i < 30; i++) pend.push_back(8'($urandom));
        stream_bytes(1'b0);
        check_val("midload_ready", ld_ready, 32'd1);
        start_clear(1'b1);
        for (int i = 0; i < 6; i++) pend.push_back(8'($urandom));
        stream_bytes(1'b1);
        finish_checks();
        check_val("restart_words", ld_words, 32'd2);
        for (int a = 0; a < 32; a += 4) fetch_one(32'(a));
        check_val("restart_old_zero", fetch_instr, 32'd0);
        fetch_idle();

        // Asynchronous reset in the middle of CLEAR.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        repeat (50) step();
        check_val("midclear_busy", busy, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midclear_rst");
        step();
        rst_n = 1'b1;
        prog.delete();
        fetch_req = 1'b1; fetch_addr = 32'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("post_rst_fetch", fetch_valid, 32'd0);
        end
        fetch_req = 1'b0;
        last_be = 32'd0; last_le = 32'd0;
        start_clear(1'b0);
        for (int i = 0; i < 8; i++) pend.push_back(8'($urandom));
        stream_bytes(1'b1);
        finish_checks();
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the pipelined CPU's IF stage. It replaces file-initialised instruction storage with a run-time byte-stream loader. The loader clears the array, then packs incoming bytes big-endian into words. A registered, one-cycle-latency fetch port with fault detection serves the IF stage once a program is loaded.

## Interface
- `DEPTH`, 128: words of storage; power of two, ≥4.
- `ADDR_W`, 32: fetch address width (byte address).
- `BIG_ENDIAN`, 1: 1 puts the first byte of each group in [31:24]; 0 puts it in [7:0].

- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ld_start` input 1: pulse that (re)starts a load session.
- `ld_valid` input 1: `ld_byte` is valid this cycle.
- `ld_byte` input 8: program byte.
- `ld_last` input 1: qualifies the final byte of the program.
- `ld_ready` output 1: loader accepts a byte this cycle.
- `ld_overflow` output 1: sticky; a byte arrived beyond DEPTH*4. Cleared by `ld_start`.
- `ld_words` output $clog2(DEPTH+1): words written in this session.
- `busy` output 1: high in CLEAR or LOAD.
- `fetch_req` input 1: fetch request, address sampled this cycle.
- `fetch_addr` input ADDR_W: byte address.
- `fetch_valid` output 1: response valid.
- `fetch_instr` output 32: instruction.
- `fetch_fault` output 1: response is a fault.

## Operation
- States are IDLE, CLEAR, LOAD and READY. Reset enters IDLE.
- **IDLE:** `ld_start` moves to CLEAR. Fetch requests are ignored.
- **CLEAR:** writes zero to word 0 through word DEPTH-1, one word per cycle, so the state lasts DEPTH cycles. It then moves to LOAD. `ld_ready`=0.
- **LOAD:** `ld_ready`=1.
  - Each accepted byte (`ld_valid`=1) goes to a lane chosen by the 2-bit lane counter, per `BIG_ENDIAN`.
  - On the 4th byte the word is written at the word pointer, the pointer increments, `ld_words` increments and the lane counter wraps to 0.
  - `ld_last` with a partial word writes that word with unfilled lanes zero, then moves to READY.
  - `ld_last` on a full word also moves to READY.
- **Overflow:** when the pointer reaches DEPTH, further bytes are dropped and `ld_overflow` is set. The state stays in LOAD until `ld_last`.
- **READY:** serves fetches. `ld_start` re-enters CLEAR.
- **ld_start priority:** `ld_start` in any state restarts CLEAR from word 0 and zeroes the pointer, lane counter, `ld_words` and `ld_overflow`. If `ld_start` and `ld_valid` occur in the same cycle, `ld_start` wins and the byte is dropped.
- **Fetch fault:** a fetch faults when `fetch_addr[1:0]`≠0 or `fetch_addr`>>2 ≥ DEPTH. A fault response has `fetch_instr`=0 and `fetch_fault`=1.
- **Fetch outside READY:** `fetch_req` in IDLE, CLEAR or LOAD produces no response.
- **Reset mid-operation:** the state returns to IDLE and all counters and outputs go to their reset values. Array contents are not guaranteed, and READY needs a fresh `ld_start`.

## Timing
- Reset values: `ld_ready`=0, `ld_overflow`=0, `ld_words`=0, `busy`=0, `fetch_valid`=0, `fetch_instr`=0, `fetch_fault`=0.
- Fetch latency is 1 cycle: a request in cycle N responds in N+1. Back-to-back requests every cycle are supported. Response outputs hold their values while `fetch_valid`=0.
- `busy` rises the cycle after `ld_start` is sampled.
- Load duration is exactly DEPTH cycles of CLEAR, then one byte per cycle maximum.
- A word write lands in the cycle its 4th byte (or `ld_last`) is sampled. READY begins the next cycle, so the first fetch can be issued the cycle after `ld_last`.
- No combinational path from fetch inputs to fetch outputs.

## Structure
- Package `instr_mem_pkg` holds:
  - the `state_t` enum (IDLE, CLEAR, LOAD, READY);
  - the constants `BYTES_PER_WORD`=4 and `INSTR_W`=32.
- Sub-module `instr_byte_packer`:
  - inputs: byte in, valid, last and clear;
  - outputs: assembled 32-bit word, `word_valid` and `partial`;
  - owns the lane counter and endian selection.
- The top level owns the FSM, pointer, array and fetch port.

## Test plan
- **Clear and load:** `ld_start`, wait 128 cycles, stream bytes 00 50 05 13 then `ld_last` with `BIG_ENDIAN`=1. Expect `ld_words`=1, and a fetch of 0x0 the next cycle returns 0x00500513. Fetch of 0x4 returns 0.
- **Partial last word:** bytes AA BB plus `ld_last`. Expect word 0 = 0xAABB0000, and 0x0000BBAA when `BIG_ENDIAN`=0.
- **Fetch faults:** fetch 0x2 and fetch 0x200 (DEPTH=128). Expect `fetch_fault`=1 and `fetch_instr`=0 on both. Back-to-back fetches 0x0, 0x4, 0x8 return three consecutive valid words.
- **Overflow:** load 513 bytes into DEPTH=128. Expect `ld_words`=128, `ld_overflow`=1 and word 127 intact.
- **Restart mid-LOAD:** `ld_start` with a simultaneous `ld_valid`. Expect the byte dropped, `busy`=1 for 128 cycles, counters zeroed and old words read as 0.
- **Reset mid-CLEAR:** assert `rst_n`=0 mid-CLEAR. Expect all outputs at reset values immediately, and `fetch_req` produces no `fetch_valid` until the next load completes.
